// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream: applies 512-bit ChaCha keystream blocks to a valid/ready
// word stream. Keystream is fetched lazily one block at a time over a
// ks_req/ks_valid pulse handshake, sliced into DATA_W-bit words (word 0 is
// ks_data[DATA_W-1:0]) and XORed onto accepted beats. Leftover keystream is
// thrown away at message end so every message begins on a fresh block.
module chacha_xor_stream #(
  parameter int DATA_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                msg_start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic                ks_req,
  input  logic                ks_valid,
  input  logic [511:0]        ks_data,
  output logic                busy
);

  // Words per keystream block; derived from DATA_W and never overridden.
  localparam int WPB    = 512 / DATA_W;
  localparam int IDX_W  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int KEEP_W = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_HAVE
  } state_t;

  state_t                     state, state_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic                       drop, drop_n;
  logic [WPB-1:0][DATA_W-1:0] ks_buf;
  logic                       buf_load;
  logic                       accept;
  logic [DATA_W-1:0]          ks_word;
  logic [DATA_W-1:0]          xor_word;

  assign ks_word = ks_buf[idx];
  assign busy    = (state != S_EMPTY) || out_valid;

  // Next-state logic: lazy block request, drop of aborted in-flight blocks,
  // word slicing within a block; msg_start wins over everything else.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    drop_n   = drop;
    buf_load = 1'b0;
    ks_req   = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state)
      S_EMPTY: begin
        if (in_valid && !msg_start) begin
          ks_req  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (msg_start) begin
          drop_n = 1'b1;
        end
        if (ks_valid) begin
          if (drop || msg_start) begin
            drop_n  = 1'b0;
            state_n = S_EMPTY;
          end else begin
            buf_load = 1'b1;
            idx_n    = '0;
            state_n  = S_HAVE;
          end
        end
      end
      S_HAVE: begin
        if (msg_start) begin
          state_n = S_EMPTY;
          idx_n   = '0;
        end else begin
          in_ready = !out_valid || out_ready;
          accept   = in_valid && in_ready;
          if (accept) begin
            if (in_last || idx == LAST_IDX) begin
              state_n = S_EMPTY;
              idx_n   = '0;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
      end
      default: begin
        state_n = S_EMPTY;
      end
    endcase
  end

  // XOR the current keystream word onto the input and zero the masked bytes.
  always_comb begin
    xor_word = in_data ^ ks_word;
    for (int i = 0; i < KEEP_W; i++) begin
      if (!in_keep[i]) begin
        xor_word[8*i +: 8] = 8'h00;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      idx   <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      drop  <= drop_n;
    end
  end

  // Keystream block buffer, loaded only when a wanted block arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_buf <= '0;
    end else if (buf_load) begin
      ks_buf <= ks_data;
    end
  end

  // Output register: load on accept, drain on out_ready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= xor_word;
      out_keep  <= in_keep;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// Self-checking bench for chacha_xor_stream (DATA_W=128). A keystream
// responder answers ks_req with random (or preset) blocks; a message-level
// reference model XORs each message's words against the served blocks in
// order, starting a fresh block at every message and every WPB words.
module tb_chacha_xor_stream;

  localparam int DATA_W = 128;
  localparam int WPB    = 512 / DATA_W;
  localparam int KW     = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              msg_start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [KW-1:0]     in_keep = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [KW-1:0]     out_keep;
  logic              out_last;
  logic              ks_req;
  logic              ks_valid = 1'b0;
  logic [511:0]      ks_data = '0;
  logic              busy;

  int checks = 0;
  int errors = 0;

  beat_t        src_q[$];
  beat_t        exp_q[$];
  logic [511:0] served_q[$];
  logic [511:0] preset_q[$];
  logic [DATA_W-1:0] obs_q[$];
  int           out_cyc[$];
  logic [511:0] cur_blk = '0;
  int           word_pos = 0;
  bit           auto_ks = 1'b1;
  int           req_cnt = 0;
  int           stall_after = -1;
  int           stall_len = 0;

  chacha_xor_stream #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_start (msg_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .ks_req    (ks_req),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every per-phase bound.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] maskBytes(input logic [DATA_W-1:0] d,
                                                  input logic [KW-1:0] k);
    for (int i = 0; i < KW; i++) if (!k[i]) d[8*i +: 8] = 8'h00;
    return d;
  endfunction

  // Expected word j of the first directed message: 0xAA over keystream bytes.
  function automatic logic [DATA_W-1:0] t1Word(input int j);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < KW; k++) w[8*k +: 8] = 8'hAA ^ 8'(KW*j + k);
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keystream responder: answers each request after 1..3 cycles with a block.
  initial begin : responder
    forever begin
      @(negedge clk);
      #2;
      while (ks_req && auto_ks) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2;
        if (preset_q.size() > 0) ks_data = preset_q.pop_front();
        else ks_data = randBlock();
        ks_valid = 1'b1;
        served_q.push_back(ks_data);
        @(negedge clk);
        #2;
        ks_valid = 1'b0;
      end
    end
  end

  // Count cycles in which a keystream request is raised.
  initial begin : req_counter
    forever begin
      @(negedge clk);
      #3;
      if (ks_req) req_cnt++;
    end
  end

  // Reference model for one accepted beat.
  task automatic modelAccept(input beat_t b);
    beat_t e;
    if (word_pos % WPB == 0) begin
      checkOutput("block_available", served_q.size() > 0, 1);
      if (served_q.size() > 0) cur_blk = served_q.pop_front();
    end
    e.data = maskBytes(b.data ^ cur_blk[(word_pos % WPB)*DATA_W +: DATA_W], b.keep);
    e.keep = b.keep;
    e.last = b.last;
    exp_q.push_back(e);
    word_pos = b.last ? 0 : word_pos + 1;
  endtask

  task automatic queueMessage(input int n, input bit aa, input bit rand_keep,
                              input logic [KW-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = aa ? {KW{8'hAA}} : randWord();
      b.keep = rand_keep ? KW'($urandom) : '1;
      if (i == n - 1) b.keep = last_keep;
      b.last = (i == n - 1);
      src_q.push_back(b);
    end
  endtask

  // Drive queued beats and check every output beat until everything drains.
  task automatic applyStimulus(input bit rand_in, input bit rand_out);
    bit    hold = 1'b0;
    bit    prev_stall = 1'b0;
    bit    stalling;
    beat_t prev_out;
    int    cyc = 0;
    int    beats_out = 0;
    int    stall_left = stall_len;
    obs_q.delete();
    out_cyc.delete();
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      stalling = 1'b0;
      if (!hold) begin
        if (src_q.size() > 0 && (!rand_in || $urandom_range(0, 3) != 0)) begin
          in_valid = 1'b1;
          in_data  = src_q[0].data;
          in_keep  = src_q[0].keep;
          in_last  = src_q[0].last;
          hold     = 1'b1;
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      if (stall_after >= 0 && beats_out >= stall_after && stall_left > 0 && out_valid) begin
        out_ready  = 1'b0;
        stall_left--;
        stalling   = 1'b1;
      end else begin
        out_ready = rand_out ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (prev_stall) begin
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_data", out_data, prev_out.data);
        checkOutput("hold_keep", out_keep, prev_out.keep);
        checkOutput("hold_last", out_last, prev_out.last);
      end
      if (stalling) checkOutput("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        checkOutput("out_beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_keep", out_keep, e.keep);
          checkOutput("out_last", out_last, e.last);
        end
        obs_q.push_back(out_data);
        out_cyc.push_back(cyc);
        beats_out++;
      end
      if (in_valid && in_ready) begin
        modelAccept(src_q.pop_front());
        hold = 1'b0;
      end
      prev_stall        = out_valid && !out_ready;
      prev_out.data     = out_data;
      prev_out.keep     = out_keep;
      prev_out.last     = out_last;
    end
    checkOutput("drained_in_budget", src_q.size() + exp_q.size(), 0);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #5;
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin : main
    int base;
    bit got;
    logic [511:0] blk;
    logic [DATA_W-1:0] w;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_keep", out_keep, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_ks_req", ks_req, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] full block, byte-index keystream");
    for (int k = 0; k < 64; k++) blk[8*k +: 8] = 8'(k);
    preset_q.push_back(blk);
    base = req_cnt;
    queueMessage(4, 1'b1, 1'b0, '1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_req_pulses", req_cnt - base, 1);
    checkOutput("t1_beats", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      checkOutput("t1_word0", obs_q[0], t1Word(0));
      checkOutput("t1_word3", obs_q[3], t1Word(3));
    end

    $display("[TB] six beats across two blocks");
    base = req_cnt;
    queueMessage(6, 1'b0, 1'b0, '1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_req_pulses", req_cnt - base, 2);
    checkOutput("t2_beats", out_cyc.size(), 6);
    if (out_cyc.size() == 6) begin
      checkOutput("t2_nobubble_01", out_cyc[1] - out_cyc[0], 1);
      checkOutput("t2_nobubble_12", out_cyc[2] - out_cyc[1], 1);
      checkOutput("t2_nobubble_23", out_cyc[3] - out_cyc[2], 1);
      checkOutput("t2_nobubble_45", out_cyc[5] - out_cyc[4], 1);
      checkOutput("t2_refill_gap", out_cyc[4] - out_cyc[3] >= 3, 1);
    end

    $display("[TB] partial last beat then fresh message");
    base = req_cnt;
    queueMessage(2, 1'b0, 1'b0, 16'h00FF);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_req_pulses", req_cnt - base, 1);
    if (obs_q.size() == 2) begin
      w = obs_q[1];
      checkOutput("t3_masked_upper", w[127:64], 0);
    end
    base = req_cnt;
    queueMessage(1, 1'b0, 1'b0, '1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_next_msg_req", req_cnt - base, 1);

    $display("[TB] output stall mid-block");
    stall_after = 1;
    stall_len   = 5;
    queueMessage(4, 1'b0, 1'b0, '1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_beats", obs_q.size(), 4);
    stall_after = -1;
    stall_len   = 0;

    $display("[TB] randomized messages");
    for (int m = 0; m < 10; m++) queueMessage($urandom_range(1, 9), 1'b0, 1'b1, KW'($urandom));
    applyStimulus(1'b1, 1'b1);

    $display("[TB] msg_start while a request is outstanding");
    auto_ks = 1'b0;
    base    = req_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = randWord();
    in_keep  = '1;
    in_last  = 1'b1;
    #1;
    checkOutput("t5_req", ks_req, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    msg_start = 1'b1;
    #1;
    checkOutput("t5_wait_no_req", ks_req, 0);
    checkOutput("t5_wait_in_ready", in_ready, 0);
    checkOutput("t5_wait_busy", busy, 1);
    @(negedge clk);
    msg_start = 1'b0;
    ks_data   = randBlock();
    ks_valid  = 1'b1;
    @(negedge clk);
    ks_valid = 1'b0;
    #1;
    checkOutput("t5_dropped_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("t5_no_out", out_valid, 0);
    end
    auto_ks = 1'b1;
    queueMessage(1, 1'b0, 1'b0, '1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_new_req", req_cnt - base, 2);

    $display("[TB] async reset with a pending output beat");
    out_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = randWord();
      in_keep  = '1;
      in_last  = 1'b0;
      #1;
      if (in_ready) got = 1'b1;
    end
    checkOutput("t6_accepted", got, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("t6_pre_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_in_ready", in_ready, 0);
    checkOutput("t6_rst_out_valid", out_valid, 0);
    checkOutput("t6_rst_out_data", out_data, 0);
    checkOutput("t6_rst_out_keep", out_keep, 0);
    checkOutput("t6_rst_out_last", out_last, 0);
    checkOutput("t6_rst_ks_req", ks_req, 0);
    checkOutput("t6_rst_busy", busy, 0);
    served_q.delete();
    exp_q.delete();
    src_q.delete();
    word_pos = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    auto_ks = 1'b0;
    @(negedge clk);
    ks_data  = randBlock();
    ks_valid = 1'b1;
    @(negedge clk);
    ks_valid = 1'b0;
    #1;
    checkOutput("t6_stray_busy", busy, 0);
    checkOutput("t6_stray_out_valid", out_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("t6_stray_busy_later", busy, 0);
    checkOutput("t6_stray_in_ready", in_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
